// File: rtl/vector_checker.sv
// rtl/vector_checker.sv - streams test vectors into a combinational DUT and tallies mismatches
module vector_checker #(
  parameter int NIN    = 3,
  parameter int NOUT   = 1,
  parameter int SETTLE = 1,
  parameter int CNTW   = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            vec_valid,
  output logic            vec_ready,
  input  logic [NIN-1:0]  vec_in,
  input  logic [NOUT-1:0] vec_exp,
  input  logic            vec_last,
  output logic [NIN-1:0]  dut_in,
  input  logic [NOUT-1:0] dut_out,
  output logic [CNTW-1:0] vec_count,
  output logic [CNTW-1:0] err_count,
  output logic [CNTW-1:0] first_err_idx,
  output logic            first_err_valid,
  output logic            done,
  output logic            pass
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Settle counter starts at SETTLE-1 so APPLY spans exactly SETTLE cycles.
  localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE - 1);
  localparam logic [CNTW-1:0] CNT_MAX     = '1;
  localparam logic [CNTW-1:0] CNT_ONE     = CNTW'(1);

  state_e          state_q;
  logic [3:0]      settle_q;
  logic [NIN-1:0]  dut_in_q;
  logic [NOUT-1:0] exp_q;
  logic            last_q;
  logic [CNTW-1:0] vec_count_q;
  logic [CNTW-1:0] err_count_q;
  logic [CNTW-1:0] first_err_idx_q;
  logic            first_err_valid_q;
  logic            done_q;

  logic [CNTW-1:0] vec_count_d;
  logic [CNTW-1:0] err_count_d;
  logic            mismatch;

  // A restart request blocks acceptance even in IDLE so it never races a handshake.
  assign vec_ready = (state_q == ST_IDLE) && !clear;
  assign mismatch  = (dut_out != exp_q);

  // Saturating next values for the two statistics counters.
  always_comb begin
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    if (vec_count_q != CNT_MAX) begin
      vec_count_d = vec_count_q + CNT_ONE;
    end
    if (err_count_q != CNT_MAX) begin
      err_count_d = err_count_q + CNT_ONE;
    end
  end

  // Sequencer: accept a vector, hold it for the settle window, score it, then idle or finish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      settle_q          <= '0;
      dut_in_q          <= '0;
      exp_q             <= '0;
      last_q            <= 1'b0;
      vec_count_q       <= '0;
      err_count_q       <= '0;
      first_err_idx_q   <= '0;
      first_err_valid_q <= 1'b0;
      done_q            <= 1'b0;
    end else if (clear) begin
      // dut_in deliberately keeps its last pattern across a restart.
      state_q           <= ST_IDLE;
      vec_count_q       <= '0;
      err_count_q       <= '0;
      first_err_idx_q   <= '0;
      first_err_valid_q <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vec_valid && vec_ready) begin
            dut_in_q <= vec_in;
            exp_q    <= vec_exp;
            last_q   <= vec_last;
            settle_q <= SETTLE_INIT;
            state_q  <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (settle_q == 4'd0) begin
            state_q <= ST_CHECK;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        ST_CHECK: begin
          vec_count_q <= vec_count_d;
          if (mismatch) begin
            err_count_q <= err_count_d;
            if (!first_err_valid_q) begin
              first_err_idx_q   <= vec_count_q;
              first_err_valid_q <= 1'b1;
            end
          end
          done_q  <= last_q;
          state_q <= last_q ? ST_DONE : ST_IDLE;
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dut_in          = dut_in_q;
  assign vec_count       = vec_count_q;
  assign err_count       = err_count_q;
  assign first_err_idx   = first_err_idx_q;
  assign first_err_valid = first_err_valid_q;
  assign done            = done_q;
  assign pass            = done_q && (err_count_q == '0);

endmodule

// File: tb/tb_vector_checker.sv
// tb/tb_vector_checker.sv - randomized model-checked bench for two vector_checker configurations
module tb_vector_checker;

  localparam int SA = 1;
  localparam int SB = 4;

  logic clk;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  logic       rst_n [2];
  logic       clr   [2];
  logic       vv    [2];
  logic [2:0] vi    [2];
  logic       ve    [2];
  logic       vl    [2];

  logic       rdy  [2];
  logic [2:0] din  [2];
  logic       dout [2];
  logic [7:0] vc   [2];
  logic [7:0] ec   [2];
  logic [7:0] fi   [2];
  logic       fv   [2];
  logic       dn   [2];
  logic       ps   [2];

  logic       a_rdy, b_rdy, a_fv, b_fv, a_dn, b_dn, a_ps, b_ps, a_dout, b_dout;
  logic [2:0] a_din, b_din;
  logic [7:0] a_vc, a_ec, a_fi;
  logic [2:0] b_vc, b_ec, b_fi;

  // Truth table of the scored function, bit k = output for input k.
  logic [7:0] truth_tbl = 8'b0011_0001;

  function automatic logic silly(input logic [2:0] x);
    return (~x[2] & ~x[1] & ~x[0]) | (x[2] & ~x[1] & ~x[0]) | (x[2] & ~x[1] & x[0]);
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? SA : SB;
  endfunction

  function automatic int cmax_of(input int i);
    return (i == 0) ? 255 : 7;
  endfunction

  assign a_dout = silly(a_din);
  assign b_dout = silly(b_din);

  assign rdy[0] = a_rdy;  assign rdy[1] = b_rdy;
  assign din[0] = a_din;  assign din[1] = b_din;
  assign dout[0] = a_dout; assign dout[1] = b_dout;
  assign vc[0] = a_vc;    assign vc[1] = {5'd0, b_vc};
  assign ec[0] = a_ec;    assign ec[1] = {5'd0, b_ec};
  assign fi[0] = a_fi;    assign fi[1] = {5'd0, b_fi};
  assign fv[0] = a_fv;    assign fv[1] = b_fv;
  assign dn[0] = a_dn;    assign dn[1] = b_dn;
  assign ps[0] = a_ps;    assign ps[1] = b_ps;

  vector_checker #(.NIN(3), .NOUT(1), .SETTLE(SA), .CNTW(8)) u_a (
    .clk(clk), .reset_n(rst_n[0]), .clear(clr[0]),
    .vec_valid(vv[0]), .vec_ready(a_rdy), .vec_in(vi[0]), .vec_exp(ve[0]), .vec_last(vl[0]),
    .dut_in(a_din), .dut_out(a_dout),
    .vec_count(a_vc), .err_count(a_ec), .first_err_idx(a_fi), .first_err_valid(a_fv),
    .done(a_dn), .pass(a_ps)
  );

  vector_checker #(.NIN(3), .NOUT(1), .SETTLE(SB), .CNTW(3)) u_b (
    .clk(clk), .reset_n(rst_n[1]), .clear(clr[1]),
    .vec_valid(vv[1]), .vec_ready(b_rdy), .vec_in(vi[1]), .vec_exp(ve[1]), .vec_last(vl[1]),
    .dut_in(b_din), .dut_out(b_dout),
    .vec_count(b_vc), .err_count(b_ec), .first_err_idx(b_fi), .first_err_valid(b_fv),
    .done(b_dn), .pass(b_ps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int i, input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", nm, i, $time, got, exp);
    end
  endtask

  // Reference model: 0 = accepting, 1 = vector in flight, 2 = run finished.
  int         m_st [2];
  int         m_rem[2];
  int         m_vc [2];
  int         m_ec [2];
  int         m_fi [2];
  int         m_fv [2];
  logic [2:0] m_in [2];
  logic [2:0] m_din[2];
  logic       m_exp[2];
  logic       m_last[2];

  function automatic void mdl_reset(input int i);
    m_st[i] = 0; m_rem[i] = 0; m_vc[i] = 0; m_ec[i] = 0; m_fi[i] = 0; m_fv[i] = 0;
    m_in[i] = '0; m_din[i] = '0; m_exp[i] = 1'b0; m_last[i] = 1'b0;
  endfunction

  initial begin
    int old;
    for (int i = 0; i < 2; i++) mdl_reset(i);
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n[i]) begin
          mdl_reset(i);
        end else if (clr[i]) begin
          m_vc[i] = 0; m_ec[i] = 0; m_fi[i] = 0; m_fv[i] = 0; m_st[i] = 0;
        end else if (m_st[i] == 0) begin
          if (vv[i]) begin
            m_din[i] = vi[i]; m_in[i] = vi[i]; m_exp[i] = ve[i]; m_last[i] = vl[i];
            m_rem[i] = settle_of(i) + 1;
            m_st[i]  = 1;
          end
        end else if (m_st[i] == 1) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            old = m_vc[i];
            if (m_vc[i] < cmax_of(i)) m_vc[i]++;
            if (truth_tbl[m_in[i]] != m_exp[i]) begin
              if (m_ec[i] < cmax_of(i)) m_ec[i]++;
              if (m_fv[i] == 0) begin
                m_fi[i] = old;
                m_fv[i] = 1;
              end
            end
            m_st[i] = m_last[i] ? 2 : 0;
          end
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n[i]) mdl_reset(i);
        chk(i, "vec_ready", rdy[i], (m_st[i] == 0 && !clr[i]) ? 1 : 0);
        chk(i, "dut_in", din[i], m_din[i]);
        chk(i, "vec_count", vc[i], m_vc[i]);
        chk(i, "err_count", ec[i], m_ec[i]);
        chk(i, "first_err_idx", fi[i], m_fi[i]);
        chk(i, "first_err_valid", fv[i], m_fv[i]);
        chk(i, "done", dn[i], (m_st[i] == 2) ? 1 : 0);
        chk(i, "pass", ps[i], (m_st[i] == 2 && m_ec[i] == 0) ? 1 : 0);
      end
    end
  end

  // All tasks start and end 2ns after a rising edge.
  task automatic send(input int i, input logic [2:0] vin, input logic e, input logic l,
                      input int gap, output int hs_cyc);
    logic got;
    if (gap > 0) begin
      vv[i] = 1'b0;
      for (int k = 0; k < gap; k++) begin
        @(posedge clk); #2;
      end
    end
    vv[i] = 1'b1; vi[i] = vin; ve[i] = e; vl[i] = l;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = rdy[i];
      @(posedge clk); #2;
    end
    if (!got) chk(i, "handshake_timeout", 0, 1);
    hs_cyc = cyc;
  endtask

  task automatic do_clear(input int i, input int n);
    clr[i] = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #2;
    end
    clr[i] = 1'b0;
  endtask

  task automatic run_exhaustive(input int i, input bit inj, input int exp_sp, input int exp_vc,
                                input int exp_ec, input int exp_fi, input int exp_fv, input int exp_ps);
    logic [7:0] e_bits;
    logic [2:0] v3;
    int prev, hs;
    e_bits = 8'b0011_0001;
    if (inj) e_bits = e_bits | 8'b1000_0100;
    prev = 0;
    for (int v = 0; v < 8; v++) begin
      v3 = 3'(v);
      send(i, v3, e_bits[v3], (v == 7), 0, hs);
      if (v > 0) chk(i, "handshake_spacing", hs - prev, exp_sp);
      prev = hs;
    end
    vv[i] = 1'b0;
    repeat (settle_of(i) + 2) @(negedge clk);
    chk(i, "run_done", dn[i], 1);
    chk(i, "run_pass", ps[i], exp_ps);
    chk(i, "run_vec_count", vc[i], exp_vc);
    chk(i, "run_err_count", ec[i], exp_ec);
    chk(i, "run_first_err_valid", fv[i], exp_fv);
    if (exp_fv != 0) chk(i, "run_first_err_idx", fi[i], exp_fi);
    @(posedge clk); #2;
  endtask

  task automatic rand_run(input int i);
    int hs, gap;
    logic [2:0] vin;
    logic e, l;
    do_clear(i, 1);
    for (int k = 0; k < 60; k++) begin
      gap = $urandom_range(0, 3);
      vin = 3'($urandom);
      e   = truth_tbl[vin] ^ ($urandom_range(0, 3) == 0);
      l   = ($urandom_range(0, 9) == 0);
      send(i, vin, e, l, gap, hs);
      if ($urandom_range(0, 14) == 0) begin
        do_clear(i, 1);
      end else if (l) begin
        vv[i] = 1'b0;
        repeat (settle_of(i) + 2) @(negedge clk);
        @(posedge clk); #2;
        do_clear(i, 1 + $urandom_range(0, 1));
      end
    end
    vv[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs, nsent, nmis;
    logic [2:0] vin;
    logic e;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; clr[i] = 1'b0; vv[i] = 1'b0; vi[i] = '0; ve[i] = 1'b0; vl[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(i, "reset_ready", rdy[i], 1);
      chk(i, "reset_count", vc[i], 0);
      chk(i, "reset_dut_in", din[i], 0);
      chk(i, "reset_done", dn[i], 0);
    end
    @(posedge clk); #2;

    // Exhaustive pass and injected errors on the SETTLE=1 instance.
    run_exhaustive(0, 1'b0, 3, 8, 0, 0, 0, 1);
    do_clear(0, 1);
    run_exhaustive(0, 1'b1, 3, 8, 2, 2, 1, 0);
    do_clear(0, 1);

    // Random gaps and held valid during busy cycles.
    nsent = 0; nmis = 0;
    for (int k = 0; k < 20; k++) begin
      vin = 3'($urandom);
      e   = truth_tbl[vin] ^ $urandom_range(0, 1);
      if (e != truth_tbl[vin]) nmis++;
      send(0, vin, e, (k == 19), $urandom_range(0, 4), hs);
      nsent++;
    end
    vv[0] = 1'b0;
    repeat (SA + 2) @(negedge clk);
    chk(0, "gaps_vec_count", vc[0], nsent);
    chk(0, "gaps_err_count", ec[0], nmis);
    @(posedge clk); #2;
    do_clear(0, 1);

    // Clear during APPLY of vector 3, including a clear cycle that overlaps valid in IDLE.
    for (int v = 0; v < 4; v++) send(0, 3'(v), truth_tbl[v], 1'b0, 0, hs);
    clr[0] = 1'b1;
    @(negedge clk);
    chk(0, "count_before_clear", vc[0], 3);
    chk(0, "ready_during_clear", rdy[0], 0);
    @(posedge clk); #2;
    @(negedge clk);
    chk(0, "ready_clear_idle", rdy[0], 0);
    chk(0, "count_cleared", vc[0], 0);
    @(posedge clk); #2;
    clr[0] = 1'b0; vv[0] = 1'b0;
    @(negedge clk);
    chk(0, "ready_after_clear", rdy[0], 1);
    chk(0, "count_after_clear", vc[0], 0);
    chk(0, "done_after_clear", dn[0], 0);
    @(posedge clk); #2;
    run_exhaustive(0, 1'b0, 3, 8, 0, 0, 0, 1);
    do_clear(0, 1);

    // Reset pulse during CHECK aborts the vector in flight.
    send(0, 3'b001, 1'b1, 1'b0, 0, hs);
    send(0, 3'b010, 1'b1, 1'b0, 0, hs);
    vv[0] = 1'b0;
    @(posedge clk); #2;
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk(0, "reset_mid_count", vc[0], 0);
    @(posedge clk); #2;
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk(0, "reset_mid_ready", rdy[0], 1);
    chk(0, "reset_mid_err", ec[0], 0);
    chk(0, "reset_mid_fv", fv[0], 0);
    @(posedge clk); #2;
    run_exhaustive(0, 1'b1, 3, 8, 2, 2, 1, 0);

    // SETTLE=4: statistics move exactly at E+5 and dut_in holds meanwhile.
    send(1, 3'b100, 1'b1, 1'b0, 0, hs);
    vv[1] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(1, "settle_before_E5", vc[1], 0);
    chk(1, "settle_dut_in", din[1], 3'b100);
    @(negedge clk);
    chk(1, "settle_at_E5", vc[1], 1);
    chk(1, "settle_ready_after", rdy[1], 1);
    @(posedge clk); #2;
    do_clear(1, 1);
    run_exhaustive(1, 1'b0, 6, 7, 0, 0, 0, 1);
    do_clear(1, 1);

    // Saturation with a 3-bit counter: ten mismatching vectors.
    for (int k = 0; k < 10; k++) begin
      vin = 3'(k % 8);
      send(1, vin, ~truth_tbl[vin], (k == 9), 0, hs);
    end
    vv[1] = 1'b0;
    repeat (SB + 2) @(negedge clk);
    chk(1, "sat_vec_count", vc[1], 7);
    chk(1, "sat_err_count", ec[1], 7);
    chk(1, "sat_first_idx", fi[1], 0);
    chk(1, "sat_first_valid", fv[1], 1);
    chk(1, "sat_pass", ps[1], 0);
    @(posedge clk); #2;

    fork
      rand_run(0);
      rand_run(1);
    join
    repeat (10) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
